fetch_pc_unit: RTL and testbench

- Instruction-fetch stage that sits directly upstream of the instruction ROM. It holds the PC and drives the ROM word address `addr[9:0]`.
- It captures the returned `instr` into the IF/ID pipeline register.
- Next-PC selection is sequential, single-issue MIPS with one branch-delay slot. Redirects are resolved in ID using the PC held in IF/ID.
- Stall and flush come from the hazard unit.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_pc_unit_npc_sel.sv | 47 ++++
 rtl/fetch_pc_unit.sv | 115 +++++++++++
 tb/tb_fetch_pc_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: reset PC, NOP encoding,
// next-PC select encoding and the branch-target helper.
package fetch_pkg;

    localparam logic [31:0] PC_BASE_DEF = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;

    typedef enum logic [1:0] {
        NPC_SEQ = 2'd0,
        NPC_BR  = 2'd1,
        NPC_J   = 2'd2,
        NPC_JR  = 2'd3
    } npc_sel_e;

    // Branch offsets are word offsets relative to the delay-slot address.
    function automatic logic [31:0] br_target(input logic [31:0] pc_id,
                                              input logic [15:0] off);
        logic signed [31:0] off_ext;
        off_ext = {{14{off[15]}}, off, 2'b00};
        return pc_id + 32'd4 + off_ext;
    endfunction

endpackage

// File: rtl/fetch_pc_unit_npc_sel.sv
// Combinational next-PC selection: jr > jmp > taken branch > sequential.
// Redirect requests are only honoured while IF/ID holds a real instruction.
module npc_sel
    import fetch_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [31:0] id_pc_i,
    input  logic        id_valid_i,
    input  logic        br_taken_i,
    input  logic [15:0] br_off_i,
    input  logic        jmp_i,
    input  logic [25:0] jmp_idx_i,
    input  logic        jr_i,
    input  logic [31:0] jr_tgt_i,
    output logic [31:0] next_pc_o
);

    npc_sel_e    sel;
    logic [3:0]  jmp_region;
    logic [31:0] jmp_tgt;
    logic [31:0] br_tgt;

    // Jump region is taken from the delay-slot address, not from id_pc itself.
    assign jmp_region = 4'((id_pc_i + 32'd4) >> 28);
    assign jmp_tgt    = {jmp_region, jmp_idx_i, 2'b00};
    assign br_tgt     = br_target(id_pc_i, br_off_i);

    always_comb begin
        sel = NPC_SEQ;
        if (id_valid_i) begin
            if (jr_i)            sel = NPC_JR;
            else if (jmp_i)      sel = NPC_J;
            else if (br_taken_i) sel = NPC_BR;
        end
    end

    always_comb begin
        next_pc_o = pc_i + 32'd4;
        case (sel)
            NPC_JR:  next_pc_o = jr_tgt_i;
            NPC_J:   next_pc_o = jmp_tgt;
            NPC_BR:  next_pc_o = br_tgt;
            default: next_pc_o = pc_i + 32'd4;
        endcase
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch stage: PC register, ROM word address, IF/ID register with stall/flush.
// Optional FETCH_ADDR_CHECK_EN adds sticky addr_err and squashes bad fetches.
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] PC_BASE = PC_BASE_DEF,
    parameter int          IM_AW   = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             br_taken,
    input  logic [15:0]      br_off,
    input  logic             jmp,
    input  logic [25:0]      jmp_idx,
    input  logic             jr,
    input  logic [31:0]      jr_tgt,
    input  logic [31:0]      instr,
    output logic [IM_AW-1:0] addr,
    output logic [31:0]      pc,
    output logic [31:0]      id_instr,
    output logic [31:0]      id_pc,
    output logic [31:0]      id_pc8,
    output logic             id_valid
`ifdef FETCH_ADDR_CHECK_EN
    ,
    output logic             addr_err
`endif
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] next_pc;
    logic [31:0] fetch_instr;

    npc_sel u_npc_sel (
        .pc_i       (pc_q),
        .id_pc_i    (id_pc_q),
        .id_valid_i (id_valid_q),
        .br_taken_i (br_taken),
        .br_off_i   (br_off),
        .jmp_i      (jmp),
        .jmp_idx_i  (jmp_idx),
        .jr_i       (jr),
        .jr_tgt_i   (jr_tgt),
        .next_pc_o  (next_pc)
    );

    // Out-of-range PCs simply alias into the ROM through truncation.
    assign addr = IM_AW'((pc_q - PC_BASE) >> 2);

`ifdef FETCH_ADDR_CHECK_EN
    localparam logic [32:0] PC_LIMIT = {1'b0, PC_BASE} + (33'd1 << (IM_AW + 2));

    logic addr_err_q, addr_err_d;
    logic pc_ok;

    assign pc_ok = (pc_q[1:0] == 2'b00) && (pc_q >= PC_BASE) && ({1'b0, pc_q} < PC_LIMIT);

    always_comb begin
        fetch_instr = pc_ok ? instr : NOP_INSTR;
        addr_err_d  = addr_err_q | (!stall && !flush && !pc_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) addr_err_q <= 1'b0;
        else        addr_err_q <= addr_err_d;
    end

    assign addr_err = addr_err_q;
`else
    assign fetch_instr = instr;
`endif

    always_comb begin
        pc_d       = stall ? pc_q : next_pc;
        id_instr_d = id_instr_q;
        id_pc_d    = id_pc_q;
        id_valid_d = id_valid_q;
        // Flush inserts a bubble even while stalled; the delay slot is never squashed by a redirect.
        if (flush) begin
            id_instr_d = NOP_INSTR;
            id_pc_d    = 32'd0;
            id_valid_d = 1'b0;
        end else if (!stall) begin
            id_instr_d = fetch_instr;
            id_pc_d    = pc_q;
            id_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= PC_BASE;
            id_instr_q <= NOP_INSTR;
            id_pc_q    <= 32'd0;
            id_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
            id_valid_q <= id_valid_d;
        end
    end

    assign pc       = pc_q;
    assign id_instr = id_instr_q;
    assign id_pc    = id_pc_q;
    assign id_pc8   = id_pc_q + 32'd8;
    assign id_valid = id_valid_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit; ROM word k returns 32'h1000_0000 + k.
module tb_fetch_pc_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        br_taken;
    logic [15:0] br_off;
    logic        jmp;
    logic [25:0] jmp_idx;
    logic        jr;
    logic [31:0] jr_tgt;
    logic [31:0] instr;
    logic [9:0]  addr;
    logic [31:0] pc;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc8;
    logic        id_valid;
`ifdef FETCH_ADDR_CHECK_EN
    logic        addr_err;
`endif

    int vec  = 0;
    int miss = 0;

    fetch_pc_unit #(.PC_BASE(32'h0000_3000), .IM_AW(10)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .stall    (stall),
        .flush    (flush),
        .br_taken (br_taken),
        .br_off   (br_off),
        .jmp      (jmp),
        .jmp_idx  (jmp_idx),
        .jr       (jr),
        .jr_tgt   (jr_tgt),
        .instr    (instr),
        .addr     (addr),
        .pc       (pc),
        .id_instr (id_instr),
        .id_pc    (id_pc),
        .id_pc8   (id_pc8),
        .id_valid (id_valid)
`ifdef FETCH_ADDR_CHECK_EN
        ,
        .addr_err (addr_err)
`endif
    );

    assign instr = 32'h1000_0000 + {22'd0, addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 0; flush = 0; br_taken = 0; br_off = 0;
        jmp = 0; jmp_idx = 0; jr = 0; jr_tgt = 0;
        repeat (2) @(posedge clk);
        #1;
        vec++; if (pc !== 32'h3000) begin miss++; $display("FAIL rst_pc got %h want %h", pc, 32'h3000); end
        vec++; if (addr !== 10'd0) begin miss++; $display("FAIL rst_addr got %h want %h", addr, 10'd0); end
        vec++; if (id_instr !== 32'h0) begin miss++; $display("FAIL rst_id_instr got %h want %h", id_instr, 32'h0); end
        vec++; if (id_pc !== 32'h0) begin miss++; $display("FAIL rst_id_pc got %h want %h", id_pc, 32'h0); end
        vec++; if (id_pc8 !== 32'h8) begin miss++; $display("FAIL rst_id_pc8 got %h want %h", id_pc8, 32'h8); end
        vec++; if (id_valid !== 1'b0) begin miss++; $display("FAIL rst_id_valid got %b want 0", id_valid); end
`ifdef FETCH_ADDR_CHECK_EN
        vec++; if (addr_err !== 1'b0) begin miss++; $display("FAIL rst_addr_err got %b want 0", addr_err); end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [3];
        logic [31:0] exp_id [3];
        exp_pc = '{32'h3004, 32'h3008, 32'h300C};
        exp_id = '{32'h3000, 32'h3004, 32'h3008};
        for (int k = 0; k < 3; k++) begin
            step();
            vec++; if (pc !== exp_pc[k]) begin miss++; $display("FAIL seq%0d_pc got %h want %h", k, pc, exp_pc[k]); end
            vec++; if (addr !== 10'(k + 1)) begin miss++; $display("FAIL seq%0d_addr got %h want %h", k, addr, 10'(k + 1)); end
            vec++; if (id_instr !== 32'h1000_0000 + k) begin miss++; $display("FAIL seq%0d_id_instr got %h want %h", k, id_instr, 32'h1000_0000 + k); end
            vec++; if (id_pc !== exp_id[k]) begin miss++; $display("FAIL seq%0d_id_pc got %h want %h", k, id_pc, exp_id[k]); end
            vec++; if (id_valid !== 1'b1) begin miss++; $display("FAIL seq%0d_id_valid got %b want 1", k, id_valid); end
        end
        vec++; if (id_pc8 !== 32'h3010) begin miss++; $display("FAIL seq_id_pc8 got %h want %h", id_pc8, 32'h3010); end
    endtask

    task automatic test_branch();
        br_taken = 1'b1; br_off = 16'hFFFE;
        step();
        br_taken = 1'b0;
        vec++; if (pc !== 32'h3004) begin miss++; $display("FAIL br_pc got %h want %h", pc, 32'h3004); end
        vec++; if (id_instr !== 32'h1000_0003) begin miss++; $display("FAIL br_slot_instr got %h want %h", id_instr, 32'h1000_0003); end
        vec++; if (id_pc !== 32'h300C) begin miss++; $display("FAIL br_slot_pc got %h want %h", id_pc, 32'h300C); end
    endtask

    task automatic test_jump();
        jr = 1'b1; jr_tgt = 32'h3010;
        step();
        jr = 1'b0;
        vec++; if (pc !== 32'h3010) begin miss++; $display("FAIL jr_setup_pc got %h want %h", pc, 32'h3010); end
        step();
        vec++; if (id_pc !== 32'h3010) begin miss++; $display("FAIL jmp_setup_id_pc got %h want %h", id_pc, 32'h3010); end
        jmp = 1'b1; jmp_idx = 26'h0000C10;
        step();
        vec++; if (pc !== 32'h3040) begin miss++; $display("FAIL jmp_pc got %h want %h", pc, 32'h3040); end
        vec++; if (id_instr !== 32'h1000_0005) begin miss++; $display("FAIL jmp_slot_instr got %h want %h", id_instr, 32'h1000_0005); end
        jr = 1'b1; jr_tgt = 32'h3100;
        step();
        jr = 1'b0; jmp = 1'b0;
        vec++; if (pc !== 32'h3100) begin miss++; $display("FAIL jr_prio_pc got %h want %h", pc, 32'h3100); end
        vec++; if (id_instr !== 32'h1000_0010) begin miss++; $display("FAIL jr_prio_instr got %h want %h", id_instr, 32'h1000_0010); end
    endtask

    task automatic test_stall();
        jr = 1'b1; jr_tgt = 32'h3010;
        step();
        jr = 1'b0;
        br_taken = 1'b1; br_off = 16'h0004; stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            vec++; if (pc !== 32'h3010) begin miss++; $display("FAIL stall%0d_pc got %h want %h", k, pc, 32'h3010); end
            vec++; if (id_pc !== 32'h3100) begin miss++; $display("FAIL stall%0d_id_pc got %h want %h", k, id_pc, 32'h3100); end
            vec++; if (id_instr !== 32'h1000_0040) begin miss++; $display("FAIL stall%0d_id_instr got %h want %h", k, id_instr, 32'h1000_0040); end
            vec++; if (id_valid !== 1'b1) begin miss++; $display("FAIL stall%0d_id_valid got %b want 1", k, id_valid); end
        end
        stall = 1'b0;
        step();
        br_taken = 1'b0;
        vec++; if (pc !== 32'h3114) begin miss++; $display("FAIL stall_release_pc got %h want %h", pc, 32'h3114); end
        vec++; if (id_pc !== 32'h3010) begin miss++; $display("FAIL stall_release_id_pc got %h want %h", id_pc, 32'h3010); end
        vec++; if (id_instr !== 32'h1000_0004) begin miss++; $display("FAIL stall_release_instr got %h want %h", id_instr, 32'h1000_0004); end
    endtask

    task automatic test_flush_stall();
        flush = 1'b1; stall = 1'b1;
        step();
        flush = 1'b0; stall = 1'b0;
        vec++; if (pc !== 32'h3114) begin miss++; $display("FAIL fl_pc got %h want %h", pc, 32'h3114); end
        vec++; if (id_valid !== 1'b0) begin miss++; $display("FAIL fl_id_valid got %b want 0", id_valid); end
        vec++; if (id_instr !== 32'h0) begin miss++; $display("FAIL fl_id_instr got %h want %h", id_instr, 32'h0); end
        vec++; if (id_pc8 !== 32'h8) begin miss++; $display("FAIL fl_id_pc8 got %h want %h", id_pc8, 32'h8); end
        // Redirect presented while IF/ID is a bubble must be ignored.
        br_taken = 1'b1; br_off = 16'h0010;
        step();
        br_taken = 1'b0;
        vec++; if (pc !== 32'h3118) begin miss++; $display("FAIL bubble_redirect_pc got %h want %h", pc, 32'h3118); end
        vec++; if (id_instr !== 32'h1000_0045) begin miss++; $display("FAIL bubble_next_instr got %h want %h", id_instr, 32'h1000_0045); end
        vec++; if (id_valid !== 1'b1) begin miss++; $display("FAIL bubble_next_valid got %b want 1", id_valid); end
    endtask

    task automatic test_flush_redirect();
        flush = 1'b1; jr = 1'b1; jr_tgt = 32'h3020;
        step();
        flush = 1'b0; jr = 1'b0;
        vec++; if (pc !== 32'h3020) begin miss++; $display("FAIL flr_pc got %h want %h", pc, 32'h3020); end
        vec++; if (id_valid !== 1'b0) begin miss++; $display("FAIL flr_id_valid got %b want 0", id_valid); end
        step();
        vec++; if (pc !== 32'h3024) begin miss++; $display("FAIL flr_next_pc got %h want %h", pc, 32'h3024); end
        vec++; if (id_instr !== 32'h1000_0008) begin miss++; $display("FAIL flr_next_instr got %h want %h", id_instr, 32'h1000_0008); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_instr;
        jr = 1'b1; jr_tgt = 32'hFFFF_FFFC;
        step();
        jr = 1'b0;
        vec++; if (pc !== 32'hFFFF_FFFC) begin miss++; $display("FAIL wrap_pc0 got %h want %h", pc, 32'hFFFF_FFFC); end
        vec++; if (addr !== 10'h3FF) begin miss++; $display("FAIL wrap_addr0 got %h want %h", addr, 10'h3FF); end
        step();
`ifdef FETCH_ADDR_CHECK_EN
        exp_instr = 32'h0;
`else
        exp_instr = 32'h1000_03FF;
`endif
        vec++; if (pc !== 32'h0) begin miss++; $display("FAIL wrap_pc1 got %h want %h", pc, 32'h0); end
        vec++; if (addr !== 10'h0) begin miss++; $display("FAIL wrap_addr1 got %h want %h", addr, 10'h0); end
        vec++; if (id_instr !== exp_instr) begin miss++; $display("FAIL wrap_instr got %h want %h", id_instr, exp_instr); end
        vec++; if (id_pc8 !== 32'h4) begin miss++; $display("FAIL wrap_id_pc8 got %h want %h", id_pc8, 32'h4); end
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        vec++; if (pc !== 32'h3000) begin miss++; $display("FAIL arst_pc got %h want %h", pc, 32'h3000); end
        vec++; if (id_valid !== 1'b0) begin miss++; $display("FAIL arst_id_valid got %b want 0", id_valid); end
        vec++; if (id_pc8 !== 32'h8) begin miss++; $display("FAIL arst_id_pc8 got %h want %h", id_pc8, 32'h8); end
`ifdef FETCH_ADDR_CHECK_EN
        vec++; if (addr_err !== 1'b0) begin miss++; $display("FAIL arst_addr_err got %b want 0", addr_err); end
`endif
        #1 rst_n = 1'b1;
        step();
        vec++; if (pc !== 32'h3004) begin miss++; $display("FAIL arst_next_pc got %h want %h", pc, 32'h3004); end
        vec++; if (id_pc !== 32'h3000) begin miss++; $display("FAIL arst_first_id_pc got %h want %h", id_pc, 32'h3000); end
        vec++; if (id_instr !== 32'h1000_0000) begin miss++; $display("FAIL arst_first_instr got %h want %h", id_instr, 32'h1000_0000); end
    endtask

`ifdef FETCH_ADDR_CHECK_EN
    task automatic test_addr_check();
        jr = 1'b1; jr_tgt = 32'h3002;
        step();
        jr = 1'b0;
        vec++; if (addr_err !== 1'b0) begin miss++; $display("FAIL ac_pre_err got %b want 0", addr_err); end
        step();
        vec++; if (id_instr !== 32'h0) begin miss++; $display("FAIL ac_instr got %h want %h", id_instr, 32'h0); end
        vec++; if (id_valid !== 1'b1) begin miss++; $display("FAIL ac_valid got %b want 1", id_valid); end
        vec++; if (addr_err !== 1'b1) begin miss++; $display("FAIL ac_err got %b want 1", addr_err); end
        jr = 1'b1; jr_tgt = 32'h3000;
        step();
        jr = 1'b0;
        step();
        vec++; if (id_instr !== 32'h1000_0000) begin miss++; $display("FAIL ac_recover_instr got %h want %h", id_instr, 32'h1000_0000); end
        vec++; if (addr_err !== 1'b1) begin miss++; $display("FAIL ac_sticky got %b want 1", addr_err); end
        #1 rst_n = 1'b0;
        #1;
        vec++; if (addr_err !== 1'b0) begin miss++; $display("FAIL ac_reset_err got %b want 0", addr_err); end
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        rst_n = 1'b1;
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_stall();
        test_flush_stall();
        test_flush_redirect();
        test_wrap();
        test_async_reset();
`ifdef FETCH_ADDR_CHECK_EN
        test_addr_check();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
